// File: rtl/ysyx_24120013_imem_responder_if.sv
// Fetch-side bus between the core (master) and the instruction memory
// responder (slave): request channel, response channel and the side-band
// load port used to place the program image.
interface ysyx_24120013_imem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ysyx_24120013_imem_responder.sv
// Instruction memory responder: single outstanding fetch, fixed latency,
// valid/ready on both channels, plus an always-active load port that
// writes the word array. Bad addresses return zero data with rsp_err set.
module ysyx_24120013_imem_responder #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                   LATENCY    = 2
) (
    input logic clk,
    input logic rst,
    ysyx_24120013_imem_responder_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    // Byte span of the array; one bit wider than an address so a full-span
    // array does not wrap the limit to zero.
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(4) << DEPTH_LOG2;
    // Counter preload: LATENCY-2 extra WAIT cycles; LATENCY==1 skips WAIT.
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Shared decode for both ports: offset from base, aligned and in range.
    logic [ADDR_WIDTH-1:0] req_off, ld_off;
    logic                  req_ok, ld_ok;
    logic [DEPTH_LOG2-1:0] req_idx, ld_idx;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  accept;

    assign req_off = bus.req_addr - BASE_ADDR;
    assign ld_off  = bus.ld_addr  - BASE_ADDR;
    assign req_ok  = (bus.req_addr[1:0] == 2'b00) && ({1'b0, req_off} < LIMIT);
    assign ld_ok   = (bus.ld_addr[1:0]  == 2'b00) && ({1'b0, ld_off}  < LIMIT);
    assign req_idx = req_off[DEPTH_LOG2+1:2];
    assign ld_idx  = ld_off[DEPTH_LOG2+1:2];

    // The array read happens in the same edge as a possible load write, so
    // the captured word is always the pre-write contents.
    assign rsp_data_d = req_ok ? mem_q[req_idx] : '0;
    assign accept     = bus.req_valid && (state_q == S_IDLE);

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    // Program image writes; array is never cleared, writes are held off
    // while reset is asserted and bad addresses are silently dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (rst && bus.ld_en && ld_ok) begin
            mem_q[ld_idx] <= bus.ld_data;
        end
    end

    // Request FSM: capture response at acceptance, count out the latency,
    // then hold the response until the core takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rsp_data_q <= rsp_data_d;
                        rsp_err_q  <= !req_ok;
                        cnt_q      <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
